// File: rtl/regfile_sb.sv
// Integer register file with two bypassed read ports and a busy scoreboard for long-latency results.
// Raises hazard_stall when a consumed operand or the destination is still waiting on a load.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  wb_we,
  input  logic [ADDR_W-1:0]     wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  issue_valid,
  input  logic                  issue_long,
  input  logic [ADDR_W-1:0]     issue_rd,
  input  logic                  flush,
  output logic                  hazard_stall,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [DATA_WIDTH-1:0] rf_view [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  wb_write;
  logic                  issue_set;
  logic                  pend_rs1;
  logic                  pend_rs2;
  logic                  pend_rd;

  // x0 is re-gated here even though writeback already filters it.
  assign wb_write  = wb_we && (wb_rd != '0);
  assign issue_set = issue_valid && issue_long && (issue_rd != '0) && !hazard_stall && !flush;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
    if (gi == 0) begin : gen_zero
      assign rf_view[gi] = '0;
      assign busy_d[gi]  = 1'b0;
    end else begin : gen_live
      logic [DATA_WIDTH-1:0] data_q;
      logic [DATA_WIDTH-1:0] data_d;
      logic                  hit_wb;
      logic                  hit_issue;

      assign hit_wb    = wb_write && (wb_rd == ADDR_W'(gi));
      assign hit_issue = issue_set && (issue_rd == ADDR_W'(gi));

      always_comb begin
        data_d = data_q;
        if (hit_wb) begin
          data_d = wb_wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign rf_view[gi] = data_q;
      // The issuing instruction is younger than the retiring one, so its set wins.
      assign busy_d[gi]  = flush     ? 1'b0 :
                           hit_issue ? 1'b1 :
                           hit_wb    ? 1'b0 : busy_q[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      if (wb_we && (wb_rd == rs1_addr)) begin
        rs1_data = wb_wdata;
      end else begin
        rs1_data = rf_view[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      if (wb_we && (wb_rd == rs2_addr)) begin
        rs2_data = wb_wdata;
      end else begin
        rs2_data = rf_view[rs2_addr];
      end
    end
  end

  // A writeback landing this cycle resolves the dependency through the bypass path.
  assign pend_rs1 = busy_q[rs1_addr] && !(wb_we && (wb_rd == rs1_addr));
  assign pend_rs2 = busy_q[rs2_addr] && !(wb_we && (wb_rd == rs2_addr));
  assign pend_rd  = busy_q[issue_rd] && !(wb_we && (wb_rd == issue_rd));

  assign hazard_stall = issue_valid && (
                          (rs1_used && (rs1_addr != '0) && pend_rs1) ||
                          (rs2_used && (rs2_addr != '0) && pend_rs2) ||
                          ((issue_rd != '0) && pend_rd));

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_used, rs2_used;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        hazard_stall;
  logic [31:0] busy_vec;

  regfile_sb #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .flush(flush), .hazard_stall(hazard_stall), .busy_vec(busy_vec)
  );

  localparam int S_RS1 = 0, S_RS2 = 1, S_STALL = 2, S_BUSY = 3;

  int          q_sel [$];
  logic [31:0] q_exp [$];
  string       q_name [$];
  int          checks = 0;
  int          failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input int sel, input logic [31:0] v, input string n);
    q_sel.push_back(sel);
    q_exp.push_back(v);
    q_name.push_back(n);
  endtask

  task automatic idle();
    wb_we = 0; wb_rd = 0; wb_wdata = 0;
    issue_valid = 0; issue_long = 0; issue_rd = 0;
    rs1_used = 0; rs2_used = 0; rs1_addr = 0; rs2_addr = 0; flush = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int          sel;
    logic [31:0] e;
    logic [31:0] a;
    string       n;
    while (q_sel.size() > 0) begin
      sel = q_sel.pop_front();
      e   = q_exp.pop_front();
      n   = q_name.pop_front();
      case (sel)
        S_RS1:   a = rs1_data;
        S_RS2:   a = rs2_data;
        S_STALL: a = {31'b0, hazard_stall};
        default: a = busy_vec;
      endcase
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle();
    #1;
    rs1_addr = 1; rs2_addr = 31;
    expect_out(S_BUSY, 32'h0, "reset_busy");
    expect_out(S_RS1, 32'h0, "reset_rs1");
    expect_out(S_RS2, 32'h0, "reset_rs2");
    next_cycle();
    next_cycle();
    rst_n = 1;

    // 1) all registers read zero, then write/read x5
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(32 - i);
      expect_out(S_RS1, 32'h0, $sformatf("zero_rs1_x%0d", i));
      expect_out(S_RS2, 32'h0, $sformatf("zero_rs2_x%0d", 32 - i));
      next_cycle();
    end
    idle(); wb_we = 1; wb_rd = 5; wb_wdata = 32'hDEAD_BEEF;
    next_cycle();
    idle(); rs1_addr = 5;
    expect_out(S_RS1, 32'hDEAD_BEEF, "x5_array_read");
    next_cycle();

    // 2) dual-port bypass
    idle(); wb_we = 1; wb_rd = 7; wb_wdata = 32'h1234_5678; rs1_addr = 7; rs2_addr = 7;
    expect_out(S_RS1, 32'h1234_5678, "bypass_rs1_x7");
    expect_out(S_RS2, 32'h1234_5678, "bypass_rs2_x7");
    next_cycle();
    idle(); rs2_addr = 7; rs1_addr = 5;
    expect_out(S_RS2, 32'h1234_5678, "x7_array_read");
    expect_out(S_RS1, 32'hDEAD_BEEF, "x5_held");
    next_cycle();

    // 3) x0 stays zero
    idle(); wb_we = 1; wb_rd = 0; wb_wdata = 32'hFFFF_FFFF;
    expect_out(S_RS1, 32'h0, "x0_same_cycle");
    expect_out(S_RS2, 32'h0, "x0_same_cycle_rs2");
    next_cycle();
    idle();
    expect_out(S_RS1, 32'h0, "x0_next_cycle");
    expect_out(S_BUSY, 32'h0, "x0_no_busy");
    next_cycle();

    // 4) long issue to x10, RAW/WAW stalls, writeback resolves
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 10;
    expect_out(S_STALL, 32'h0, "issue_x10_nostall");
    expect_out(S_BUSY, 32'h0, "busy_before_set");
    next_cycle();
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 11; rs1_addr = 10; rs1_used = 1;
    expect_out(S_STALL, 32'h1, "raw_rs1_stall");
    expect_out(S_BUSY, 32'h0000_0400, "busy_x10_set");
    next_cycle();
    idle(); issue_valid = 1; issue_rd = 12; rs2_addr = 10; rs2_used = 0;
    expect_out(S_STALL, 32'h0, "unused_rs2_nostall");
    expect_out(S_BUSY, 32'h0000_0400, "stalled_issue_no_set");
    next_cycle();
    idle(); issue_valid = 1; issue_rd = 10;
    expect_out(S_STALL, 32'h1, "waw_stall");
    next_cycle();
    idle(); rs2_addr = 10; rs2_used = 1;
    expect_out(S_STALL, 32'h0, "no_issue_no_stall");
    next_cycle();
    idle(); issue_valid = 1; issue_rd = 12; rs1_addr = 10; rs1_used = 1;
    wb_we = 1; wb_rd = 10; wb_wdata = 32'hCAFE_F00D;
    expect_out(S_STALL, 32'h0, "wb_resolves_stall");
    expect_out(S_RS1, 32'hCAFE_F00D, "wb_bypass_x10");
    expect_out(S_BUSY, 32'h0000_0400, "busy_until_edge");
    next_cycle();
    idle(); rs1_addr = 10;
    expect_out(S_BUSY, 32'h0, "busy_x10_cleared");
    expect_out(S_RS1, 32'hCAFE_F00D, "x10_array_read");
    next_cycle();

    // 5) set beats clear, flush clears and overrides set, wb still commits
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 3;
    next_cycle();
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 3;
    wb_we = 1; wb_rd = 3; wb_wdata = 32'h0000_0033;
    expect_out(S_STALL, 32'h0, "waw_resolved_by_wb");
    expect_out(S_BUSY, 32'h0000_0008, "busy_x3_pre");
    next_cycle();
    idle(); flush = 1; issue_valid = 1; issue_long = 1; issue_rd = 21; rs1_addr = 3; rs1_used = 1;
    expect_out(S_BUSY, 32'h0000_0008, "set_beats_clear");
    expect_out(S_STALL, 32'h1, "flush_no_mask_stall");
    next_cycle();
    idle(); flush = 1; issue_valid = 1; issue_long = 1; issue_rd = 21;
    wb_we = 1; wb_rd = 22; wb_wdata = 32'h0000_2222;
    expect_out(S_BUSY, 32'h0, "flush_cleared");
    expect_out(S_STALL, 32'h0, "flush_cycle_nostall");
    next_cycle();
    idle(); rs1_addr = 22; rs2_addr = 3;
    expect_out(S_BUSY, 32'h0, "flush_overrides_set");
    expect_out(S_RS1, 32'h0000_2222, "wb_during_flush");
    expect_out(S_RS2, 32'h0000_0033, "x3_written");
    next_cycle();

    // 6) asynchronous reset mid-operation
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 4;
    wb_we = 1; wb_rd = 4; wb_wdata = 32'h0000_4444;
    next_cycle();
    idle(); rs1_addr = 4; rs2_addr = 7;
    expect_out(S_BUSY, 32'h0000_0010, "busy_x4");
    expect_out(S_RS1, 32'h0000_4444, "x4_before_reset");
    next_cycle();
    idle(); rs1_addr = 4; rs2_addr = 7;
    rst_n = 0;
    expect_out(S_BUSY, 32'h0, "async_reset_busy");
    expect_out(S_RS1, 32'h0, "async_reset_x4");
    expect_out(S_RS2, 32'h0, "async_reset_x7");
    next_cycle();
    rst_n = 1;
    idle(); rs1_addr = 5; rs2_addr = 10;
    expect_out(S_RS1, 32'h0, "after_reset_x5");
    expect_out(S_RS2, 32'h0, "after_reset_x10");
    next_cycle();

    @(negedge clk);
    #1;
    if (q_sel.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q_sel.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
